// File: rtl/multi_cycle_mips.sv
// Multi-cycle MIPS-subset core with a shared instruction/data memory port.
// Each instruction walks FETCH/DECODE/EXEC/MEM/WB; halt and illegal encodings park the core in HALT.
module multi_cycle_mips #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic [31:0]      pc_out,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t state;
  state_t next_state;

  logic [31:0]      pc;
  logic [31:0]      ir;
  logic [31:0]      a;
  logic [31:0]      b;
  logic [31:0]      alu_out;
  logic [31:0]      mdr;
  logic [31:0]      regs [32];
  logic [CNT_W-1:0] retired_q;
  logic             illegal_q;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] imm_sext;
  logic [25:0] imm26;
  logic        legal;
  logic        branch_taken;
  logic [31:0] alu_result;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: return 1'b1;
          default:                               return 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_HALT: return 1'b1;
      default:                                             return 1'b0;
    endcase
  endfunction

  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm26    = ir[25:0];
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};
  assign legal    = is_legal(opcode, funct);

  assign branch_taken = (opcode == OP_BEQ) ? (a == b) : (a != b);
  assign wb_dest      = (opcode == OP_RTYPE) ? rd : rt;
  assign wb_data      = (opcode == OP_LW) ? mdr : alu_out;

  // ALU: R-type by funct, everything else is A plus the sign-extended immediate
  always_comb begin
    alu_result = 32'h0000_0000;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_ADD:  alu_result = a + b;
        FN_SUB:  alu_result = a - b;
        FN_AND:  alu_result = a & b;
        FN_OR:   alu_result = a | b;
        FN_SLT:  alu_result = {31'h0000_0000, ($signed(a) < $signed(b))};
        default: alu_result = 32'h0000_0000;
      endcase
    end else begin
      alu_result = a + imm_sext;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH: begin
        if (mem_ready) next_state = S_DECODE;
        else           next_state = S_FETCH;
      end
      S_DECODE: begin
        if ((opcode == OP_HALT) || !legal) next_state = S_HALT;
        else                               next_state = S_EXEC;
      end
      S_EXEC: begin
        case (opcode)
          OP_RTYPE, OP_ADDI: next_state = S_WB;
          OP_LW, OP_SW:      next_state = S_MEM;
          default:           next_state = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ready) next_state = (opcode == OP_SW) ? S_FETCH : S_WB;
        else           next_state = S_MEM;
      end
      S_WB:    next_state = S_FETCH;
      S_HALT:  next_state = S_HALT;
      default: next_state = S_FETCH;
    endcase
  end

  // Bus and status outputs; reset forces the request side quiet in the same cycle
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = {pc[31:2], 2'b00};
    halted   = 1'b0;
    illegal  = 1'b0;
    if (!rst) begin
      halted  = (state == S_HALT);
      illegal = illegal_q;
      case (state)
        S_FETCH: mem_req = 1'b1;
        S_MEM: begin
          mem_req  = 1'b1;
          mem_we   = (opcode == OP_SW);
          mem_addr = {alu_out[31:2], 2'b00};
        end
        default: mem_req = 1'b0;
      endcase
    end else begin
      mem_req = 1'b0;
    end
  end

  assign mem_wdata = b;
  assign pc_out    = pc;
  assign retired   = retired_q;

  // Datapath registers, register file and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      ir        <= 32'h0000_0000;
      a         <= 32'h0000_0000;
      b         <= 32'h0000_0000;
      alu_out   <= 32'h0000_0000;
      mdr       <= 32'h0000_0000;
      retired_q <= '0;
      illegal_q <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'h0000_0000;
      end
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            ir <= mem_rdata;
            pc <= pc + 32'd4;
          end
        end
        S_DECODE: begin
          a         <= regs[rs];
          b         <= regs[rt];
          illegal_q <= !legal;
        end
        S_EXEC: begin
          case (opcode)
            OP_RTYPE, OP_ADDI, OP_LW, OP_SW: alu_out <= alu_result;
            OP_BEQ, OP_BNE: begin
              // pc already holds the address of the next instruction here
              if (branch_taken) pc <= pc + {imm_sext[29:0], 2'b00};
              retired_q <= retired_q + CNT_ONE;
            end
            OP_J: begin
              pc        <= {pc[31:28], imm26, 2'b00};
              retired_q <= retired_q + CNT_ONE;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (opcode == OP_SW) retired_q <= retired_q + CNT_ONE;
            else                 mdr <= mem_rdata;
          end
        end
        S_WB: begin
          if (wb_dest != 5'd0) regs[wb_dest] <= wb_data;
          retired_q <= retired_q + CNT_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_mips.sv
// Scoreboarded bench for multi_cycle_mips: an ISA-level model predicts every bus transfer,
// its cycle (counted without wait cycles), and the final halted/illegal/retired state.
module tb_multi_cycle_mips;
  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ready, halted, illegal;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out, retired;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cyc;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] img [0:2047];
  logic [31:0] mem [0:2047];
  logic [31:0] mm  [0:2047];
  int          n_chk = 0, n_err = 0;
  int          wait_mode = 0, ld_pc;
  bit          force_rdy = 1'b0, load_req = 1'b0, mon_en = 1'b0;
  int          nw_cnt, halt_cyc;
  logic [31:0] halt_ret;

  multi_cycle_mips #(.RESET_PC(RPC), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc_out(pc_out), .halted(halted), .illegal(illegal), .retired(retired)
  );

  initial forever #5 clk = ~clk;

  function automatic int midx(input logic [31:0] a);
    return int'({a[22], a[11:2]});
  endfunction

  assign mem_rdata = mem[midx(mem_addr)];

  function automatic logic [31:0] enc_r(input int rd, input int rs, input int rt, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] target);
    return {6'h02, target[27:2]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 2048; i++) img[i] = 32'h0;
    ld_pc = RPC;
  endtask
  task automatic put(input logic [31:0] w);
    img[midx(ld_pc)] = w;
    ld_pc += 4;
  endtask
  task automatic put_at(input logic [31:0] a, input logic [31:0] w);
    img[midx(a)] = w;
  endtask

  // Instruction-set reference: one loop iteration per instruction, latency from the cycle table
  task automatic run_model(output int ret, output bit ill, output int hc);
    logic [31:0] r [32];
    logic [31:0] pc, ir, sx, ea, va, vb;
    logic [5:0]  op;
    int          cyc, lat;
    for (int i = 0; i < 32; i++) r[i] = 32'h0;
    for (int i = 0; i < 2048; i++) mm[i] = img[i];
    pc = RPC; cyc = 0; ret = 0; ill = 1'b0; hc = -1;
    exp_q.delete();
    for (int step = 0; step < 500; step++) begin
      ir = mm[midx(pc)];
      exp_q.push_back('{1'b0, pc, 32'h0, cyc});
      pc = pc + 32'd4;
      op = ir[31:26];
      sx = {{16{ir[15]}}, ir[15:0]};
      va = r[ir[25:21]];
      vb = r[ir[20:16]];
      ea = (va + sx) & 32'hFFFF_FFFC;
      lat = 0;
      case (op)
        6'h00: begin
          lat = 4;
          case (ir[5:0])
            6'h20:   r[ir[15:11]] = va + vb;
            6'h22:   r[ir[15:11]] = va - vb;
            6'h24:   r[ir[15:11]] = va & vb;
            6'h25:   r[ir[15:11]] = va | vb;
            6'h2A:   r[ir[15:11]] = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
            default: lat = 0;
          endcase
        end
        6'h08: begin r[ir[20:16]] = va + sx; lat = 4; end
        6'h23: begin
          exp_q.push_back('{1'b0, ea, 32'h0, cyc + 3});
          r[ir[20:16]] = mm[midx(ea)];
          lat = 5;
        end
        6'h2B: begin
          exp_q.push_back('{1'b1, ea, vb, cyc + 3});
          mm[midx(ea)] = vb;
          lat = 4;
        end
        6'h04: begin if (va == vb) pc = pc + (sx << 2); lat = 3; end
        6'h05: begin if (va != vb) pc = pc + (sx << 2); lat = 3; end
        6'h02: begin pc = {pc[31:28], ir[25:0], 2'b00}; lat = 3; end
        default: lat = 0;
      endcase
      r[0] = 32'h0;
      if (lat == 0) begin
        ill = (op != 6'h3F);
        hc  = cyc + 2;
        return;
      end
      ret++;
      cyc += lat;
    end
  endtask

  // Memory responder: mode 0 zero-wait, 1 two waits, 2 random waits, 3 reads only
  initial begin
    int pend, tgt;
    pend = 0; tgt = 0; mem_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (force_rdy) begin
        mem_ready = 1'b1;
      end else if (wait_mode == 3) begin
        mem_ready = mem_req && !mem_we;
      end else if (mem_req) begin
        if (pend == 0) tgt = (wait_mode == 1) ? 2 : (wait_mode == 2) ? int'($urandom_range(0, 3)) : 0;
        if (pend >= tgt) begin mem_ready = 1'b1; pend = 0; end
        else begin mem_ready = 1'b0; pend++; end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
        pend = 0;
      end
    end
  end

  // Monitor: owns the memory array, pops the scoreboard on every completed transfer
  initial begin
    txn_t        t;
    bit          prev_wait;
    logic        prev_we;
    logic [31:0] prev_addr, prev_wdata;
    prev_wait = 1'b0;
    forever begin
      @(negedge clk);
      if (load_req) begin
        for (int i = 0; i < 2048; i++) mem[i] = img[i];
      end
      if (mon_en) begin
        if (mem_req && prev_wait) begin
          chk("hold_we", mem_we, prev_we);
          chk("hold_addr", mem_addr, prev_addr);
          if (mem_we) chk("hold_wdata", mem_wdata, prev_wdata);
        end
        if (mem_req && mem_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_txn", 64'd1, 64'd0);
          end else begin
            t = exp_q.pop_front();
            chk("txn_we", mem_we, t.we);
            chk("txn_addr", mem_addr, t.addr);
            if (t.we) chk("txn_wdata", mem_wdata, t.wdata);
            chk("txn_cycle", nw_cnt, t.cyc);
            if (mem_we) mem[midx(mem_addr)] = mem_wdata;
          end
        end
        if (halted) begin
          if (halt_cyc < 0) begin
            halt_cyc = nw_cnt;
            halt_ret = retired;
          end else begin
            chk("halt_no_req", mem_req, 1'b0);
            chk("halt_retired_frozen", retired, halt_ret);
          end
        end
        prev_wait  = mem_req && !mem_ready;
        prev_we    = mem_we;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
        if (!prev_wait) nw_cnt++;
      end else begin
        prev_wait = 1'b0;
      end
    end
  end

  task automatic load_mem();
    @(posedge clk); #1 load_req = 1'b1;
    @(posedge clk); #1 load_req = 1'b0;
  endtask

  task automatic run_prog(input int mode);
    int exp_re, exp_hc;
    bit exp_il;
    run_model(exp_re, exp_il, exp_hc);
    load_mem();
    wait_mode = mode;
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("reset_req", mem_req, 1'b0);
      chk("reset_halted", halted, 1'b0);
    end
    @(posedge clk); #1 rst = 1'b0;
    nw_cnt = 0; halt_cyc = -1; mon_en = 1'b1;
    @(negedge clk);
    chk("first_fetch_req", mem_req, 1'b1);
    chk("first_fetch_addr", mem_addr, RPC);
    chk("first_retired", retired, 32'd0);
    for (int k = 0; k < 3000 && !halted; k++) @(negedge clk);
    if (!halted) chk("halt_timeout", 64'd0, 64'd1);
    repeat (4) @(negedge clk);
    mon_en = 1'b0;
    chk("halted", halted, 1'b1);
    chk("illegal", illegal, exp_il);
    chk("retired", retired, exp_re);
    chk("halt_cycle", halt_cyc, exp_hc);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  task automatic gen_random();
    int sel, rd, rs, rt;
    clear_img();
    for (int i = 1; i < 8; i++) put(enc_i(6'h08, i, 0, int'($urandom_range(0, 65535))));
    for (int i = 0; i < 24; i++) begin
      sel = int'($urandom_range(0, 9));
      rd  = int'($urandom_range(0, 7));
      rs  = int'($urandom_range(0, 7));
      rt  = int'($urandom_range(0, 7));
      case (sel)
        0: put(enc_r(rd, rs, rt, 6'h20));
        1: put(enc_r(rd, rs, rt, 6'h22));
        2: put(enc_r(rd, rs, rt, 6'h24));
        3: put(enc_r(rd, rs, rt, 6'h25));
        4: put(enc_r(rd, rs, rt, 6'h2A));
        5: put(enc_i(6'h08, rd, rs, int'($urandom_range(0, 65535))));
        6: put(enc_i(6'h2B, rt, 0, 32'h600 + 4 * int'($urandom_range(0, 15)) + int'($urandom_range(0, 3))));
        7: put(enc_i(6'h23, rd, 0, 32'h600 + 4 * int'($urandom_range(0, 15)) + int'($urandom_range(0, 3))));
        8: put(enc_i(6'h04, rt, rs, int'($urandom_range(0, 2))));
        default: put(enc_i(6'h05, rt, rs, int'($urandom_range(0, 2))));
      endcase
    end
    for (int i = 1; i < 8; i++) put(enc_i(6'h2B, i, 0, 32'h700 + 4 * i));
    repeat (3) put(HALT_W);
  endtask

  initial begin
    bit found;
    // ALU and $0, exact program: halt visible 4*5+2 cycles after release
    clear_img();
    put(enc_i(6'h08, 1, 0, 5)); put(enc_i(6'h08, 2, 0, -3)); put(enc_r(3, 1, 2, 6'h20));
    put(enc_r(4, 2, 1, 6'h2A)); put(enc_i(6'h08, 0, 0, 7)); put(HALT_W);
    run_prog(0);
    chk("alu_halt_cycle", halt_cyc, 22);
    chk("alu_retired_5", retired, 32'd5);
    chk("alu_not_illegal", illegal, 1'b0);
    // Same program, results made visible on the bus
    ld_pc = RPC + 32'h14;
    put(enc_i(6'h2B, 3, 0, 32'h50)); put(enc_i(6'h2B, 4, 0, 32'h54));
    put(enc_i(6'h2B, 0, 0, 32'h58)); put(HALT_W);
    run_prog(2);
    // Load/store with two wait cycles per request
    clear_img();
    put_at(32'h80, 32'hDEAD_BEEF);
    put(enc_i(6'h23, 6, 0, 32'h80)); put(enc_i(6'h2B, 6, 0, 32'h40));
    put(enc_i(6'h23, 5, 0, 32'h40)); put(enc_i(6'h2B, 5, 0, 32'h44)); put(HALT_W);
    run_prog(1);
    // Branches and jumps: beq taken at 0x10, bne not taken, j to 0x0040_0000 from 0x20
    clear_img();
    put_at(RPC, enc_j(32'h10));
    put_at(32'h10, enc_i(6'h04, 0, 0, -4));
    put_at(32'h04, enc_i(6'h05, 0, 0, 5));
    put_at(32'h08, enc_j(32'h20));
    put_at(32'h20, enc_j(32'h0040_0000));
    put_at(32'h0040_0000, HALT_W);
    run_prog(0);
    // Illegal opcode
    clear_img();
    put(enc_i(6'h08, 1, 0, 1)); put(32'h7C00_0000);
    run_prog(2);
    chk("illegal_set", illegal, 1'b1);
    // Randomized programs with random wait states
    for (int p = 0; p < 4; p++) begin
      gen_random();
      run_prog(2);
    end
    // Reset while sw waits in MEM, with mem_ready high in the reset cycle
    clear_img();
    put(enc_i(6'h08, 1, 0, 7)); put(enc_i(6'h2B, 1, 0, 32'h40)); put(HALT_W);
    load_mem();
    wait_mode = 3;
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (mem_req && mem_we) found = 1'b1;
    end
    chk("rst_sw_seen", found, 1'b1);
    chk("rst_sw_addr", mem_addr, 32'h40);
    chk("rst_sw_wdata", mem_wdata, 32'd7);
    chk("rst_pre_retired", retired, 32'd1);
    @(posedge clk); #1 rst = 1'b1; force_rdy = 1'b1;
    @(negedge clk);
    chk("rst_req_forced", mem_req, 1'b0);
    chk("rst_we_forced", mem_we, 1'b0);
    @(posedge clk); #1 rst = 1'b0; force_rdy = 1'b0;
    @(negedge clk);
    chk("rst_fetch_req", mem_req, 1'b1);
    chk("rst_fetch_we", mem_we, 1'b0);
    chk("rst_fetch_addr", mem_addr, RPC);
    chk("rst_pc", pc_out, RPC);
    chk("rst_retired", retired, 32'd0);
    chk("rst_halted", halted, 1'b0);
    wait_mode = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
